// File: rtl/em_ll_pkg.sv
// Shared types and default widths for the multi-channel edit-memory
// buffer linked list.
package em_ll_pkg;

  localparam int EM_BUF_PTR_NBITS     = 8;
  localparam int PORT_ID_NBITS        = 4;
  localparam int PD_CHUNK_DEPTH_NBITS = 14;
  localparam int READ_COUNT_NBITS     = 4;
  localparam int DATA_PATH_NBYTES     = 64;
  localparam int EM_LL_MAX_NCH        = 16;

  typedef struct packed {
    logic [READ_COUNT_NBITS-1:0]     read_count;
    logic [PORT_ID_NBITS-1:0]        port_id;
    logic [EM_BUF_PTR_NBITS-1:0]     buf_ptr;
    logic [PD_CHUNK_DEPTH_NBITS-1:0] pd_length;
  } em_rc_req_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WALK,
    W_WAIT
  } walk_state_e;

endpackage

// File: rtl/em_ll_chan.sv
// One read-count channel: request FIFO plus the buffer-chain walker.
// The FIFO exposes a write two cycles after it lands.
module sfifo2f_bram_pf #(
  parameter int W  = 8,
  parameter int DN = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int D = 1 << DN;

  logic [W-1:0] mem_q [D];
  logic [DN:0]  wptr_q, wvis_q, rptr_q, cnt;

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wptr_q[DN-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      wvis_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (DN+1)'(wr_i);
      wvis_q <= wptr_q;
      rptr_q <= rptr_q + (DN+1)'(rd_i);
    end
  end

  assign cnt     = wptr_q - rptr_q;
  assign full_o  = cnt[DN];
  assign empty_o = (wvis_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[DN-1:0]];

endmodule

module em_ll_chan
  import em_ll_pkg::*;
#(
  parameter int BPTR_NBITS       = EM_BUF_PTR_NBITS,
  parameter int ID_NBITS         = PORT_ID_NBITS,
  parameter int LEN_NBITS        = PD_CHUNK_DEPTH_NBITS,
  parameter int RC_NBITS         = READ_COUNT_NBITS,
  parameter int SIZE             = DATA_PATH_NBYTES,
  parameter int FIFO_DEPTH_NBITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BPTR_NBITS-1:0] buf_ptr_i,
  input  logic [ID_NBITS-1:0]   port_id_i,
  input  logic [RC_NBITS-1:0]   read_count_i,
  input  logic [LEN_NBITS-1:0]  pd_length_i,
  output logic                  overflow_o,
  input  logic                  gnt_i,
  input  logic [BPTR_NBITS-1:0] rdata_i,
  output logic                  walk_o,
  output logic [BPTR_NBITS-1:0] ptr_o,
  output logic [ID_NBITS-1:0]   port_o,
  output logic [RC_NBITS-1:0]   rc_o,
  output logic                  sop_o,
  output logic                  eop_o
);
  localparam logic [LEN_NBITS:0] SZ = (LEN_NBITS+1)'(SIZE);

  em_rc_req_t  req_in, req_out;
  logic        push, pop, empty, full, ovf_q;
  walk_state_e state_q, state_d;
  logic [BPTR_NBITS-1:0] ptr_q, ptr_d;
  logic [ID_NBITS-1:0]   port_q, port_d;
  logic [RC_NBITS-1:0]   rc_q, rc_d;
  logic [LEN_NBITS:0]    rem_q, rem_d;
  logic                  sop_q, sop_d, eop;

  always_comb begin
    req_in            = '0;
    req_in.read_count = READ_COUNT_NBITS'(read_count_i);
    req_in.port_id    = PORT_ID_NBITS'(port_id_i);
    req_in.buf_ptr    = EM_BUF_PTR_NBITS'(buf_ptr_i);
    req_in.pd_length  = PD_CHUNK_DEPTH_NBITS'(pd_length_i);
  end

  // zero-length packets own no buffers, so they never enter the FIFO
  assign push       = in_valid_i & ~full & (pd_length_i != '0);
  assign pop        = (state_q == W_IDLE) & ~empty;
  assign in_ready_o = ~full;
  assign overflow_o = ovf_q;

  sfifo2f_bram_pf #(
    .W (  $bits(em_rc_req_t)),
    .DN(FIFO_DEPTH_NBITS)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (push),
    .wdata_i(req_in),
    .rd_i   (pop),
    .rdata_o(req_out),
    .empty_o(empty),
    .full_o (full)
  );

  assign eop = (rem_q <= SZ);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    rc_d    = rc_q;
    rem_d   = rem_q;
    sop_d   = sop_q;
    unique case (state_q)
      W_IDLE: if (!empty) begin
        state_d = W_WALK;
        ptr_d   = BPTR_NBITS'(req_out.buf_ptr);
        port_d  = ID_NBITS'(req_out.port_id);
        rc_d    = RC_NBITS'(req_out.read_count);
        rem_d   = {1'b0, LEN_NBITS'(req_out.pd_length)};
        sop_d   = 1'b1;
      end
      W_WALK: if (gnt_i) begin
        sop_d = 1'b0;
        if (eop) begin
          state_d = W_IDLE;
        end else begin
          rem_d   = rem_q - SZ;
          state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        ptr_d   = rdata_i;
        state_d = W_WALK;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      ptr_q   <= '0;
      port_q  <= '0;
      rc_q    <= '0;
      rem_q   <= '0;
      sop_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      rc_q    <= rc_d;
      rem_q   <= rem_d;
      sop_q   <= sop_d;
      ovf_q   <= ovf_q | (in_valid_i & full);
    end
  end

  assign walk_o = (state_q == W_WALK);
  assign ptr_o  = ptr_q;
  assign port_o = port_q;
  assign rc_o   = rc_q;
  assign sop_o  = sop_q;
  assign eop_o  = eop;

endmodule

// File: rtl/edit_mem_linked_list_mc.sv
// Link RAM, lookup path and round-robin walker arbitration for the
// multi-channel edit-memory buffer linked list.
module ram_1r1w_ultra #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // write-first: a same-cycle read of the written address sees new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

module edit_mem_linked_list_mc
  import em_ll_pkg::*;
#(
  parameter int BPTR_NBITS       = EM_BUF_PTR_NBITS,
  parameter int ID_NBITS         = PORT_ID_NBITS,
  parameter int LEN_NBITS        = PD_CHUNK_DEPTH_NBITS,
  parameter int RC_NBITS         = READ_COUNT_NBITS,
  parameter int SIZE             = DATA_PATH_NBYTES,
  parameter int NCH              = 4,
  parameter int CH_NBITS         = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int FIFO_DEPTH_NBITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enq_buf_valid,
  input  logic [BPTR_NBITS-1:0]     enq_buf_ptr_cur,
  input  logic [BPTR_NBITS-1:0]     enq_buf_ptr_nxt,
  input  logic                      buf_req,
  input  logic [BPTR_NBITS-1:0]     buf_req_ptr,
  output logic                      buf_ack_valid,
  output logic [BPTR_NBITS-1:0]     buf_ack_ptr,
  input  logic [NCH-1:0]            rc_in_valid,
  output logic [NCH-1:0]            rc_in_ready,
  input  logic [NCH*BPTR_NBITS-1:0] rc_in_buf_ptr,
  input  logic [NCH*ID_NBITS-1:0]   rc_in_port_id,
  input  logic [NCH*RC_NBITS-1:0]   rc_in_read_count,
  input  logic [NCH*LEN_NBITS-1:0]  rc_in_pd_length,
  output logic                      read_count_valid,
  output logic [CH_NBITS-1:0]       read_count_chan,
  output logic [ID_NBITS-1:0]       read_count_port_id,
  output logic [BPTR_NBITS-1:0]     read_count_buf_ptr,
  output logic [RC_NBITS-1:0]       read_count,
  output logic                      read_count_sop,
  output logic                      read_count_eop,
  output logic [NCH-1:0]            rc_overflow,
  output logic                      inc_ll_rd_count,
  output logic                      inc_ll_wr_count
);
  logic                  wr_q;
  logic [BPTR_NBITS-1:0] waddr_q, wdata_q;
  logic                  re;
  logic [BPTR_NBITS-1:0] raddr, rdata;

  logic [NCH-1:0]        walk, gnt, ch_sop, ch_eop;
  logic [BPTR_NBITS-1:0] ch_ptr  [NCH];
  logic [ID_NBITS-1:0]   ch_port [NCH];
  logic [RC_NBITS-1:0]   ch_rc   [NCH];

  logic                  gnt_any, g_eop;
  logic [CH_NBITS-1:0]   gnt_idx, idx, rr_q;
  logic [BPTR_NBITS-1:0] g_ptr;

  logic                  req1_q, ack_v_q;
  logic [BPTR_NBITS-1:0] ack_ptr_q;
  logic                  rcv_q, sop_q, eop_q;
  logic [CH_NBITS-1:0]   chan_q;
  logic [ID_NBITS-1:0]   port_q;
  logic [BPTR_NBITS-1:0] ptr_q;
  logic [RC_NBITS-1:0]   rc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= enq_buf_valid;
      if (enq_buf_valid) begin
        waddr_q <= enq_buf_ptr_cur;
        wdata_q <= enq_buf_ptr_nxt;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    em_ll_chan #(
      .BPTR_NBITS      (BPTR_NBITS),
      .ID_NBITS        (ID_NBITS),
      .LEN_NBITS       (LEN_NBITS),
      .RC_NBITS        (RC_NBITS),
      .SIZE            (SIZE),
      .FIFO_DEPTH_NBITS(FIFO_DEPTH_NBITS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (rc_in_valid[g]),
      .in_ready_o  (rc_in_ready[g]),
      .buf_ptr_i   (rc_in_buf_ptr[g*BPTR_NBITS +: BPTR_NBITS]),
      .port_id_i   (rc_in_port_id[g*ID_NBITS +: ID_NBITS]),
      .read_count_i(rc_in_read_count[g*RC_NBITS +: RC_NBITS]),
      .pd_length_i (rc_in_pd_length[g*LEN_NBITS +: LEN_NBITS]),
      .overflow_o  (rc_overflow[g]),
      .gnt_i       (gnt[g]),
      .rdata_i     (rdata),
      .walk_o      (walk[g]),
      .ptr_o       (ch_ptr[g]),
      .port_o      (ch_port[g]),
      .rc_o        (ch_rc[g]),
      .sop_o       (ch_sop[g]),
      .eop_o       (ch_eop[g])
    );
  end

  // lookups own the read port; a preempted walker keeps its turn
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    gnt     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CH_NBITS'((int'(rr_q) + i) % NCH);
      if (!gnt_any && !buf_req && walk[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign g_ptr = ch_ptr[gnt_idx];
  assign g_eop = ch_eop[gnt_idx];
  assign raddr = buf_req ? buf_req_ptr : g_ptr;
  assign re    = buf_req | (gnt_any & ~g_eop);

  ram_1r1w_ultra #(
    .AW(BPTR_NBITS),
    .DW(BPTR_NBITS)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wr_q),
    .waddr_i(waddr_q),
    .wdata_i(wdata_q),
    .re_i   (re),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      req1_q    <= 1'b0;
      ack_v_q   <= 1'b0;
      ack_ptr_q <= '0;
      rcv_q     <= 1'b0;
      chan_q    <= '0;
      port_q    <= '0;
      ptr_q     <= '0;
      rc_q      <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      req1_q  <= buf_req;
      ack_v_q <= req1_q;
      if (req1_q) ack_ptr_q <= rdata;
      rcv_q <= gnt_any;
      if (gnt_any) begin
        rr_q   <= (gnt_idx == CH_NBITS'(NCH-1)) ? '0 : gnt_idx + 1'b1;
        chan_q <= gnt_idx;
        port_q <= ch_port[gnt_idx];
        ptr_q  <= g_ptr;
        rc_q   <= ch_rc[gnt_idx];
        sop_q  <= ch_sop[gnt_idx];
        eop_q  <= g_eop;
      end
    end
  end

  assign buf_ack_valid      = ack_v_q;
  assign buf_ack_ptr        = ack_ptr_q;
  assign inc_ll_rd_count    = req1_q;
  assign inc_ll_wr_count    = wr_q;
  assign read_count_valid   = rcv_q;
  assign read_count_chan    = chan_q;
  assign read_count_port_id = port_q;
  assign read_count_buf_ptr = ptr_q;
  assign read_count         = rc_q;
  assign read_count_sop     = sop_q;
  assign read_count_eop     = eop_q;

endmodule

// File: doc/edit_mem_linked_list_mc.md
# edit_mem_linked_list_mc

Multi-channel successor of the edit-memory buffer linked list. It holds the per-buffer next-pointer RAM, serves single-hop buffer lookups for the dequeue path, and walks packet buffer chains for `NCH` independent read-count channels. For each packet it emits one read-count update per buffer. It sits between the ASA read-count interface and the edit-memory buffer free/refcount logic; channels share the single link-RAM read port under round-robin arbitration, and buffer lookups have absolute priority.

## Interface
- `BPTR_NBITS`, default `EM_BUF_PTR_NBITS: buffer pointer width
- `ID_NBITS`, default `PORT_ID_NBITS: port id width
- `LEN_NBITS`, default `PD_CHUNK_DEPTH_NBITS: packet length width, in bytes
- `RC_NBITS`, default `READ_COUNT_NBITS: read count width
- `SIZE`, default `DATA_PATH_NBYTES: bytes per buffer
- `NCH`, default 4: read-count channels (1..16)
- `CH_NBITS`, default $clog2(NCH) (min 1): channel id width
- `FIFO_DEPTH_NBITS`, default 3: log2 of the per-channel request FIFO depth

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset; asynchronous assert, active-low
- `enq_buf_valid` in 1: link-write strobe
- `enq_buf_ptr_cur` in BPTR: RAM address to write
- `enq_buf_ptr_nxt` in BPTR: next-pointer value written
- `buf_req` in 1: single-hop lookup request
- `buf_req_ptr` in BPTR: lookup address
- `buf_ack_valid` out 1: lookup response strobe
- `buf_ack_ptr` out BPTR: `link[buf_req_ptr]`
- `rc_in_valid` in NCH: per-channel read-count request
- `rc_in_ready` out NCH: per-channel FIFO not full
- `rc_in_buf_ptr` in NCH*BPTR: head buffer of the packet
- `rc_in_port_id` in NCH*ID: port id
- `rc_in_read_count` in NCH*RC: read count
- `rc_in_pd_length` in NCH*LEN: packet length in bytes
- `read_count_valid` out 1: per-buffer update strobe
- `read_count_chan` out CH: source channel
- `read_count_port_id` out ID: port id
- `read_count_buf_ptr` out BPTR: buffer being updated
- `read_count` out RC: read count
- `read_count_sop` out 1: first buffer of the packet
- `read_count_eop` out 1: last buffer of the packet
- `rc_overflow` out NCH: sticky; set when `rc_in_valid` is asserted while `rc_in_ready` is low
- `inc_ll_rd_count` out 1: statistics pulse, one per lookup
- `inc_ll_wr_count` out 1: statistics pulse, one per link write

## Operation
- **Link RAM**
  - 2^BPTR entries of BPTR bits; one write port and one read port.
  - The enqueue inputs are registered once, and the write happens in cycle t+1.
  - The read is registered, so data appears one cycle after the address is presented.
  - If a read and a write hit the same address in the same cycle, the read returns the newly written data (write-first bypass).
- **Lookup**
  - `buf_req` takes the read port in the cycle it is asserted; no channel is granted in that cycle.
  - Back-to-back requests are accepted every cycle.
- **Request admission**
  - A channel request is written to that channel's FIFO when `rc_in_valid & rc_in_ready`.
  - A request with `pd_length==0` is dropped and does not set `rc_overflow`.
- **Channel walker**, states IDLE / WALK / WAIT:
  - IDLE: when the FIFO is non-empty, pop it, load `cur_ptr`, `port`, `rc` and `rem_len = {1'b0,len}`, then go to WALK.
  - WALK: the channel is eligible for a grant.
    - On grant: issue the update for `cur_ptr` and present `raddr = cur_ptr`.
    - `rem_len` is LEN+1 bits. eop is `rem_len <= SIZE`; otherwise `rem_len -= SIZE`.
    - eop leads to IDLE; not eop leads to WAIT.
  - WAIT: capture the RAM output into `cur_ptr` on the next cycle, then return to WALK.
- **Arbitration**
  - Round-robin over channels in WALK.
  - The pointer advances to grantee+1.
  - A channel that is preempted by `buf_req` keeps its place and is re-offered the next cycle.
- A single-buffer packet (`len <= SIZE`) produces exactly one update with sop=eop=1 and performs no RAM read.
- Buffer count per packet is ceil(len/SIZE).
- `read_count_buf_ptr` carries the RAM address presented at grant, so it never lags a preemption.

## Timing
- Reset values:
  - All outputs are 0, except `rc_in_ready`, which is all-ones.
  - All walkers go to IDLE and the FIFOs are emptied.
  - The arbitration pointer is 0 and `rc_overflow` is cleared.
  - Reset mid-walk discards that walk; no partial flush is performed.
- Lookup: `buf_req` at t gives `buf_ack_valid` and `buf_ack_ptr` at t+2. `inc_ll_rd_count` pulses at t+1.
- Enqueue: `enq_buf_valid` at t writes the RAM at t+1 and pulses `inc_ll_wr_count` at t+1. A lookup of the same address issued at t+1 or later sees the new value.
- Request to first update:
  - FIFO write at t, pop at t+2 (FIFO latency 2), WALK at t+3.
  - The update is registered one cycle after grant.
  - Minimum total latency is 4 cycles.
- Per-channel pacing: at most one update every 2 cycles (grant, then WAIT). Aggregate throughput is 1 update/cycle when two or more channels are walking and `buf_req` is idle.
- `rc_in_ready` deasserts in the same cycle the FIFO count reaches its depth.

## Structure
- Package `em_ll_pkg` holds:
  - `em_rc_req_t` struct {read_count, port_id, buf_ptr, pd_length}
  - walker state enum
  - `EM_LL_MAX_NCH` = 16
- Sub-module `em_ll_chan` contains one channel: `sfifo2f_bram_pf` plus the walker FSM. It is instantiated NCH times with a generate loop.
- The top level holds the link RAM (`ram_1r1w_ultra` with write-first bypass), the arbiter and the output registers.

## Test plan
- **Enqueue then lookup:** enqueue 5→9 at t0; `buf_req` 5 at t1 → ack valid at t3 with ptr 9. A same-cycle collision (enqueue 7→3 with `buf_req` 7 one cycle later) returns 3.
- **Single channel, len=3*SIZE:** chain 10→11→12 → three updates, ptrs 10, 11, 12, 2 cycles apart. Flags are sop on 10 and eop on 12; chan=0, port and rc constant.
- **Boundaries:**
  - len=SIZE → one update, sop=eop=1.
  - len=SIZE+1 → two updates.
  - len=0 → no update and `rc_overflow` stays 0.
- **Four channels walking concurrently:** updates appear 1/cycle, channel order 0,1,2,3,0,…; every chain completes intact.
- **`buf_req` asserted every other cycle during a 2-channel walk:** acks are correct at +2, no update is lost or duplicated, and the walk order is preserved.
- **Overflow and reset:**
  - Fill a FIFO (8 entries, walker stalled by continuous `buf_req`) → `rc_in_ready`=0. A 9th valid sets `rc_overflow[ch]`.
  - Assert `rst_n` low mid-walk → outputs 0 and `rc_in_ready` all-ones.
